// File: rtl/rob_pair_buffer.sv
// Reorder buffer of two-slot rows. Dispatch allocates rows in order, writebacks complete slots,
// and the head row is offered to commit once every valid slot in it has completed.
module rob_pair_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned UOP_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic             disp_valid,
  input  logic             disp_v0,
  input  logic             disp_v1,
  input  logic [UOP_W-1:0] disp_uop0,
  input  logic [UOP_W-1:0] disp_uop1,
  output logic             disp_ready,
  output logic [IDX_W-1:0] disp_row,

  input  logic             wb0_valid,
  input  logic [IDX_W:0]   wb0_tag,
  input  logic             wb0_exc,
  input  logic             wb0_taken,
  input  logic [31:0]      wb0_addr,
  input  logic             wb1_valid,
  input  logic [IDX_W:0]   wb1_tag,
  input  logic             wb1_exc,
  input  logic             wb1_taken,
  input  logic [31:0]      wb1_addr,

  output logic             commit_valid,
  input  logic             commit_ready,
  output logic             commit_v0,
  output logic             commit_v1,
  output logic [UOP_W-1:0] commit_uop0,
  output logic [UOP_W-1:0] commit_uop1,
  output logic             commit_exc0,
  output logic             commit_exc1,
  output logic             commit_taken0,
  output logic             commit_taken1,
  output logic [31:0]      commit_addr0,
  output logic [31:0]      commit_addr1
);

  localparam logic [IDX_W:0] Full = (IDX_W + 1)'(DEPTH);

  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q, count_d;

  logic             slot_v     [DEPTH][2];
  logic             slot_busy  [DEPTH][2];
  logic             slot_exc   [DEPTH][2];
  logic             slot_taken [DEPTH][2];
  logic [31:0]      slot_addr  [DEPTH][2];
  logic [UOP_W-1:0] slot_uop   [DEPTH][2];

  logic             disp_fire, pop_fire, not_empty;
  logic [IDX_W-1:0] wb0_row, wb1_row;
  logic             wb0_slot, wb1_slot;

  assign wb0_row  = wb0_tag[IDX_W:1];
  assign wb0_slot = wb0_tag[0];
  assign wb1_row  = wb1_tag[IDX_W:1];
  assign wb1_slot = wb1_tag[0];

  assign not_empty  = (count_q != '0);
  assign disp_ready = (count_q != Full) && !flush;
  assign disp_row   = tail_q;
  assign disp_fire  = disp_valid && disp_ready;

  assign commit_valid = not_empty
                        && (!slot_v[head_q][0] || !slot_busy[head_q][0])
                        && (!slot_v[head_q][1] || !slot_busy[head_q][1]);
  assign pop_fire = commit_valid && commit_ready;

  // Head fields are forced to zero while empty so stale rows never leak out.
  always_comb begin
    commit_v0     = 1'b0;
    commit_v1     = 1'b0;
    commit_uop0   = '0;
    commit_uop1   = '0;
    commit_exc0   = 1'b0;
    commit_exc1   = 1'b0;
    commit_taken0 = 1'b0;
    commit_taken1 = 1'b0;
    commit_addr0  = '0;
    commit_addr1  = '0;
    if (not_empty) begin
      commit_v0     = slot_v[head_q][0];
      commit_v1     = slot_v[head_q][1];
      commit_uop0   = slot_uop[head_q][0];
      commit_uop1   = slot_uop[head_q][1];
      commit_exc0   = slot_exc[head_q][0];
      commit_exc1   = slot_exc[head_q][1];
      commit_taken0 = slot_taken[head_q][0];
      commit_taken1 = slot_taken[head_q][1];
      commit_addr0  = slot_addr[head_q][0];
      commit_addr1  = slot_addr[head_q][1];
    end
  end

  always_comb begin
    count_d = count_q;
    if (disp_fire && !pop_fire) begin
      count_d = count_q + (IDX_W + 1)'(1);
    end else if (!disp_fire && pop_fire) begin
      count_d = count_q - (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < int'(DEPTH); r++) begin
        for (int s = 0; s < 2; s++) begin
          slot_v[r][s]     <= 1'b0;
          slot_busy[r][s]  <= 1'b0;
          slot_exc[r][s]   <= 1'b0;
          slot_taken[r][s] <= 1'b0;
          slot_addr[r][s]  <= '0;
        end
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < int'(DEPTH); r++) begin
        slot_v[r][0] <= 1'b0;
        slot_v[r][1] <= 1'b0;
      end
    end else begin
      // Port 1 is applied after port 0 so it wins a same-slot collision.
      if (wb0_valid && slot_v[wb0_row][wb0_slot] && slot_busy[wb0_row][wb0_slot]) begin
        slot_busy[wb0_row][wb0_slot]  <= 1'b0;
        slot_exc[wb0_row][wb0_slot]   <= wb0_exc;
        slot_taken[wb0_row][wb0_slot] <= wb0_taken;
        slot_addr[wb0_row][wb0_slot]  <= wb0_addr;
      end
      if (wb1_valid && slot_v[wb1_row][wb1_slot] && slot_busy[wb1_row][wb1_slot]) begin
        slot_busy[wb1_row][wb1_slot]  <= 1'b0;
        slot_exc[wb1_row][wb1_slot]   <= wb1_exc;
        slot_taken[wb1_row][wb1_slot] <= wb1_taken;
        slot_addr[wb1_row][wb1_slot]  <= wb1_addr;
      end
      if (pop_fire) begin
        slot_v[head_q][0] <= 1'b0;
        slot_v[head_q][1] <= 1'b0;
        head_q            <= head_q + IDX_W'(1);
      end
      if (disp_fire) begin
        slot_v[tail_q][0]     <= disp_v0;
        slot_v[tail_q][1]     <= disp_v1;
        slot_busy[tail_q][0]  <= disp_v0;
        slot_busy[tail_q][1]  <= disp_v1;
        slot_exc[tail_q][0]   <= 1'b0;
        slot_exc[tail_q][1]   <= 1'b0;
        slot_taken[tail_q][0] <= 1'b0;
        slot_taken[tail_q][1] <= 1'b0;
        slot_addr[tail_q][0]  <= '0;
        slot_addr[tail_q][1]  <= '0;
        tail_q                <= tail_q + IDX_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: it is only visible through valid, non-empty rows.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      slot_uop[tail_q][0] <= disp_uop0;
      slot_uop[tail_q][1] <= disp_uop1;
    end
  end

endmodule

// File: tb/tb_rob_pair_buffer.sv
// Directed self-checking bench for rob_pair_buffer: one task per scenario, inline comparisons.
module tb_rob_pair_buffer;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int UOP_W = 128;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             disp_valid, disp_v0, disp_v1;
  logic [UOP_W-1:0] disp_uop0, disp_uop1;
  logic             disp_ready;
  logic [IDX_W-1:0] disp_row;
  logic             wb0_valid, wb0_exc, wb0_taken;
  logic [IDX_W:0]   wb0_tag;
  logic [31:0]      wb0_addr;
  logic             wb1_valid, wb1_exc, wb1_taken;
  logic [IDX_W:0]   wb1_tag;
  logic [31:0]      wb1_addr;
  logic             commit_valid, commit_ready;
  logic             commit_v0, commit_v1;
  logic [UOP_W-1:0] commit_uop0, commit_uop1;
  logic             commit_exc0, commit_exc1, commit_taken0, commit_taken1;
  logic [31:0]      commit_addr0, commit_addr1;

  int checks = 0;
  int errors = 0;

  rob_pair_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .UOP_W(UOP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_v0(disp_v0), .disp_v1(disp_v1),
    .disp_uop0(disp_uop0), .disp_uop1(disp_uop1),
    .disp_ready(disp_ready), .disp_row(disp_row),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_exc(wb0_exc),
    .wb0_taken(wb0_taken), .wb0_addr(wb0_addr),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_exc(wb1_exc),
    .wb1_taken(wb1_taken), .wb1_addr(wb1_addr),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_v0(commit_v0), .commit_v1(commit_v1),
    .commit_uop0(commit_uop0), .commit_uop1(commit_uop1),
    .commit_exc0(commit_exc0), .commit_exc1(commit_exc1),
    .commit_taken0(commit_taken0), .commit_taken1(commit_taken1),
    .commit_addr0(commit_addr0), .commit_addr1(commit_addr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [UOP_W-1:0] pl(input int n);
    return {32'hDEAD0000 + 32'(n), 32'hBEEF0000 + 32'(n), 32'(n), ~32'(n)};
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0;
    disp_valid = 1'b0; disp_v0 = 1'b0; disp_v1 = 1'b0; disp_uop0 = '0; disp_uop1 = '0;
    wb0_valid = 1'b0; wb0_tag = '0; wb0_exc = 1'b0; wb0_taken = 1'b0; wb0_addr = '0;
    wb1_valid = 1'b0; wb1_tag = '0; wb1_exc = 1'b0; wb1_taken = 1'b0; wb1_addr = '0;
    commit_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic dispatch(input logic v0, input logic v1, input int n);
    disp_valid = 1'b1; disp_v0 = v0; disp_v1 = v1;
    disp_uop0 = pl(n); disp_uop1 = pl(n + 1000);
    tick();
    disp_valid = 1'b0; disp_v0 = 1'b0; disp_v1 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_commit_valid: got %b want 0", commit_valid);
    end
    checks++;
    if (disp_ready !== 1'b1) begin
      errors++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready);
    end
    checks++;
    if ({commit_v0, commit_v1, commit_exc0, commit_taken1, commit_addr0, commit_uop1} !== '0)
    begin
      errors++; $display("FAIL reset_commit_fields: got v0=%b v1=%b addr0=%h want zero",
                         commit_v0, commit_v1, commit_addr0);
    end
    checks++;
    if (disp_row !== 5'd0) begin
      errors++; $display("FAIL reset_disp_row: got %0d want 0", disp_row);
    end
  endtask

  task automatic test_basic();
    do_reset();
    checks++;
    if (disp_row !== 5'd0) begin
      errors++; $display("FAIL basic_disp_row: got %0d want 0", disp_row);
    end
    dispatch(1'b1, 1'b1, 7);
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL basic_busy_hold: got %b want 0", commit_valid);
    end
    wb0_valid = 1'b1; wb0_tag = 6'd0;
    tick();
    wb0_valid = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL basic_half_done: got %b want 0", commit_valid);
    end
    wb1_valid = 1'b1; wb1_tag = 6'd1; wb1_taken = 1'b1; wb1_addr = 32'h44;
    tick();
    wb1_valid = 1'b0; wb1_taken = 1'b0; wb1_addr = '0;
    #1;
    checks++;
    if (commit_valid !== 1'b1) begin
      errors++; $display("FAIL basic_commit_valid: got %b want 1", commit_valid);
    end
    checks++;
    if (commit_uop0 !== pl(7) || commit_uop1 !== pl(1007)) begin
      errors++; $display("FAIL basic_payload: got %h/%h want %h/%h",
                         commit_uop0, commit_uop1, pl(7), pl(1007));
    end
    checks++;
    if ({commit_v0, commit_v1, commit_taken1, commit_addr1} !== {3'b111, 32'h44}) begin
      errors++; $display("FAIL basic_fields: got v=%b%b t1=%b a1=%h want v=11 t1=1 a1=44",
                         commit_v0, commit_v1, commit_taken1, commit_addr1);
    end
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL basic_after_pop: got %b want 0", commit_valid);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 3 || i == DEPTH - 1) begin
        checks++;
        if (disp_ready !== 1'b1 || disp_row !== 5'(i)) begin
          errors++; $display("FAIL fill_row%0d: got ready=%b row=%0d want ready=1 row=%0d",
                             i, disp_ready, disp_row, i);
        end
      end
      dispatch(1'b1, 1'b0, 100 + i);
    end
    checks++;
    if (disp_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", disp_ready);
    end
    wb0_valid = 1'b1; wb0_tag = 6'd0;
    tick();
    wb0_valid = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b1 || commit_uop0 !== pl(100)) begin
      errors++; $display("FAIL full_head: got valid=%b uop0=%h want 1/%h",
                         commit_valid, commit_uop0, pl(100));
    end
    // Pop with a dispatch attempt in the same cycle: full buffer must refuse it.
    commit_ready = 1'b1; disp_valid = 1'b1; disp_v0 = 1'b1; disp_uop0 = pl(999);
    #1;
    checks++;
    if (disp_ready !== 1'b0) begin
      errors++; $display("FAIL full_no_bypass: got %b want 0", disp_ready);
    end
    tick();
    commit_ready = 1'b0; disp_valid = 1'b0; disp_v0 = 1'b0;
    #1;
    checks++;
    if (disp_ready !== 1'b1 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL after_pop: got ready=%b cvalid=%b want 1/0",
                         disp_ready, commit_valid);
    end
    checks++;
    if (disp_row !== 5'd0) begin
      errors++; $display("FAIL wrap_row: got %0d want 0", disp_row);
    end
    dispatch(1'b1, 1'b0, 200);
    checks++;
    if (disp_ready !== 1'b0 || disp_row !== 5'd1) begin
      errors++; $display("FAIL refull: got ready=%b row=%0d want 0/1", disp_ready, disp_row);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    dispatch(1'b1, 1'b0, 11);
    dispatch(1'b1, 1'b0, 22);
    wb0_valid = 1'b1; wb0_tag = 6'd2;
    tick();
    wb0_valid = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL order_b_first: got %b want 0", commit_valid);
    end
    wb0_valid = 1'b1; wb0_tag = 6'd0;
    tick();
    wb0_valid = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b1 || commit_uop0 !== pl(11)) begin
      errors++; $display("FAIL order_a: got valid=%b uop0=%h want 1/%h",
                         commit_valid, commit_uop0, pl(11));
    end
    commit_ready = 1'b1;
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_uop0 !== pl(22)) begin
      errors++; $display("FAIL order_b: got valid=%b uop0=%h want 1/%h",
                         commit_valid, commit_uop0, pl(22));
    end
    tick();
    commit_ready = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL order_drained: got %b want 0", commit_valid);
    end
  endtask

  task automatic test_wb_collision();
    do_reset();
    dispatch(1'b1, 1'b0, 33);
    wb0_valid = 1'b1; wb0_tag = 6'd0; wb0_addr = 32'h100; wb0_exc = 1'b1; wb0_taken = 1'b0;
    wb1_valid = 1'b1; wb1_tag = 6'd0; wb1_addr = 32'h200; wb1_exc = 1'b0; wb1_taken = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (commit_valid !== 1'b1 || commit_addr0 !== 32'h200) begin
      errors++; $display("FAIL collide_addr: got valid=%b addr0=%h want 1/00000200",
                         commit_valid, commit_addr0);
    end
    checks++;
    if (commit_taken0 !== 1'b1 || commit_exc0 !== 1'b0) begin
      errors++; $display("FAIL collide_flags: got taken0=%b exc0=%b want 1/0",
                         commit_taken0, commit_exc0);
    end
    // A second writeback to an already completed slot is ignored.
    wb0_valid = 1'b1; wb0_tag = 6'd0; wb0_addr = 32'h300; wb0_exc = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (commit_addr0 !== 32'h200 || commit_exc0 !== 1'b0) begin
      errors++; $display("FAIL stale_wb: got addr0=%h exc0=%b want 00000200/0",
                         commit_addr0, commit_exc0);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(1'b1, 1'b1, 40 + i);
    wb0_valid = 1'b1; wb0_tag = 6'd0; wb1_valid = 1'b1; wb1_tag = 6'd1;
    tick();
    idle();
    #1;
    checks++;
    if (commit_valid !== 1'b1) begin
      errors++; $display("FAIL flush_pre_valid: got %b want 1", commit_valid);
    end
    flush = 1'b1; disp_valid = 1'b1; disp_v0 = 1'b1; disp_v1 = 1'b1; commit_ready = 1'b1;
    #1;
    checks++;
    if (disp_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", disp_ready);
    end
    tick();
    idle();
    #1;
    checks++;
    if (commit_valid !== 1'b0 || disp_ready !== 1'b1 || disp_row !== 5'd0) begin
      errors++; $display("FAIL flush_empty: got cvalid=%b ready=%b row=%0d want 0/1/0",
                         commit_valid, disp_ready, disp_row);
    end
    wb0_valid = 1'b1; wb0_tag = 6'd4;
    tick();
    idle();
    #1;
    checks++;
    if (commit_valid !== 1'b0 || commit_v0 !== 1'b0) begin
      errors++; $display("FAIL late_wb: got cvalid=%b v0=%b want 0/0", commit_valid, commit_v0);
    end
    // Row 0 reused after flush must come back busy.
    dispatch(1'b1, 1'b0, 50);
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL flush_reuse_busy: got %b want 0", commit_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dispatch(1'b0, 1'b0, 60);
    checks++;
    if (commit_valid !== 1'b1 || commit_v0 !== 1'b0 || commit_v1 !== 1'b0) begin
      errors++; $display("FAIL empty_row: got valid=%b v=%b%b want 1 v=00",
                         commit_valid, commit_v0, commit_v1);
    end
    checks++;
    if (disp_row !== 5'd1) begin
      errors++; $display("FAIL empty_row_tail: got %0d want 1", disp_row);
    end
    commit_ready = 1'b1;
    dispatch(1'b0, 1'b0, 61);
    commit_ready = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b1 || disp_row !== 5'd2) begin
      errors++; $display("FAIL b2b_state: got valid=%b row=%0d want 1/2", commit_valid, disp_row);
    end
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_count: got %b want 0", commit_valid);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_full_wrap();
    test_in_order();
    test_wb_collision();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_pair_buffer.md
Name: rob_pair_buffer

Overview:
- Reorder buffer feeding the in-order commit stage.
- Dispatch allocates one row of two uOP slots per cycle, in program order. Execution writebacks clear a slot's busy flag and record its branch and exception outcome.
- The oldest row is presented to commit as a slot pair (uOP0/uOP1). It is offered only when every valid slot in that row has completed.
- A pipeline flush empties the buffer.

Parameters:
- DEPTH, 32, number of rows (two slots each); power of two.
- IDX_W, 5, log2(DEPTH); row index width.
- UOP_W, 128, width of the opaque uOP payload stored per slot.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all rows
- disp_valid  in  1  dispatch a row this cycle
- disp_v0, disp_v1  in  1 each  slot 0/1 holds a real uOP; both 0 allocates an empty row
- disp_uop0, disp_uop1  in  UOP_W each  slot payloads
- disp_ready  out  1  row can be accepted
- disp_row  out  IDX_W  row index allocated on this cycle's dispatch (equals tail pointer)
- wbN_valid  in  1  writeback port N, N = 0,1
- wbN_tag  in  IDX_W+1  {row, slot}; slot is the LSB
- wbN_exc  in  1  uOP raised an exception
- wbN_taken  in  1  resolved branch direction
- wbN_addr  in  32  resolved branch target
- commit_valid  out  1  head row is complete and offered
- commit_ready  in  1  commit stage consumes the head row
- commit_v0, commit_v1  out  1 each  head slot valid flags
- commit_uop0, commit_uop1  out  UOP_W each  head payloads
- commit_exc0, commit_exc1  out  1 each  head exception flags
- commit_taken0, commit_taken1  out  1 each  head branch direction
- commit_addr0, commit_addr1  out  32 each  head branch target

Behaviour:
- State:
  - head, tail: IDX_W-bit row pointers; wrap from DEPTH-1 to 0.
  - count: IDX_W+1 bits, range 0..DEPTH.
  - Per slot: valid, busy, exc, taken, addr, payload.
- Reset (rst=1 at clk edge):
  - head=tail=count=0.
  - All slot valid/busy/exc/taken cleared; addr zeroed.
  - Result: commit_valid=0 and all commit_* outputs 0. disp_ready=1 from the first cycle after reset.
- disp_ready = (count != DEPTH) && !flush. This is combinational. There is no full-bypass: a full buffer refuses dispatch even if commit pops in the same cycle.
- Dispatch fires when disp_valid && disp_ready:
  - Row[tail] is written with the payloads and valid flags. For each valid slot: busy=1, exc=0, taken=0, addr=0.
  - tail increments.
- Writeback fires per port when wbN_valid:
  - The addressed slot is updated at the edge if its valid=1 and busy=1: busy=0, exc/taken/addr latched.
  - A writeback to an invalid or already-completed slot is ignored.
  - If both ports target the same slot in the same cycle, port 1 wins.
- Commit:
  - commit_valid = (count != 0) && (!v0 || !busy0) && (!v1 || !busy1) at row[head]. This is combinational from registers.
  - An empty row (v0=v1=0) commits as soon as it reaches the head.
  - commit_* outputs are row[head] fields. When count==0 they are forced to 0.
  - Pop fires when commit_valid && commit_ready: the row's valid flags are cleared and head increments.
- count: next = count + dispatch_fire - pop_fire. Simultaneous dispatch and pop leaves count unchanged.
- Latency:
  - A dispatched row can reach the head and be offered at the earliest one cycle after dispatch, and only if it has no busy slot.
  - A writeback becomes visible on commit outputs the cycle after wbN_valid.
- Flush:
  - Highest priority after rst.
  - At the edge, head=tail=count=0 and all valid flags are cleared.
  - Same-cycle dispatch, writeback and pop are discarded. disp_ready is already 0 during the flush cycle.
  - commit_valid may be 1 during the flush cycle. The commit stage must not pop when it issued the flush; if it does, the flush still wins.
- Reset or flush mid-operation: in-flight writebacks arriving after the flush target invalid slots and are therefore ignored.

Test Plan:
- Reset, then dispatch row {v0=1,v1=1} → disp_row=0, commit_valid stays 0. wb0 tag=0 (row 0, slot 0), then wb1 tag=1 (row 0, slot 1) on the next cycle → commit_valid=1 the cycle after the second writeback, with commit_uop0/1 matching the dispatched payloads.
- Dispatch 32 rows with no commits → disp_ready=0 after the 32nd row and count=32. Complete and pop row 0 → disp_ready=1 next cycle. Dispatch a new row → disp_row=0 (wrap).
- Dispatch rows A, B. Complete B first → commit_valid=0 (in-order). Complete A → A commits, then B commits on the following cycle.
- Same-cycle wb0 and wb1 to tag 0 with addr 0x100 and 0x200 → commit_addr0=0x200, and commit_taken0/commit_exc0 also come from port 1.
- Fill 5 rows, assert flush with disp_valid=1 and commit_ready=1 → next cycle count=0 and commit_valid=0; the dispatched row is discarded. A late wb to tag 4 does not create a valid row.
- Dispatch an empty row (v0=v1=0) → commit_valid=1 the next cycle with commit_v0=commit_v1=0. With dispatch and pop in the same cycle → count is unchanged.
